// File: rtl/stb_hit_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stb_hit_accum_pkg
//  Description : Shared types and default widths for the strobe hit
//                accumulator (measure unit). The counter width matches the
//                strobe generator's counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package stb_hit_accum_pkg;

    typedef enum logic [1:0] {
        HA_IDLE  = 2'd0,
        HA_ARM   = 2'd1,
        HA_ACCUM = 2'd2,
        HA_DONE  = 2'd3
    } hit_accum_state_t;

    localparam int c_CNT_W          = 16;
    localparam int c_TIMEOUT_W      = 24;
    localparam int c_TIMEOUT_CYCLES = 2**20;

endpackage
`default_nettype wire

// File: rtl/stb_hit_accum_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer with asynchronous active-high reset,
//                used to bring the comparator output into clk_i.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability stage followed by the settled output stage.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule
`default_nettype wire

// File: rtl/stb_hit_accum.sv
`default_nettype none
// ============================================================================
//  Module      : stb_hit_accum
//  Description : Counts comparator hits on strobe rising edges over a
//                programmed number of strobes and hands hits/total/error to
//                the measurement controller over a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module stb_hit_accum
    import stb_hit_accum_pkg::*;
#(
    parameter int CNT_W          = c_CNT_W,
    parameter int TIMEOUT_W      = c_TIMEOUT_W,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             stb_i,
    input  logic             stb_err_i,
    input  logic             cmp_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] n_samples_i,
    output logic             busy_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [CNT_W-1:0] res_hits_o,
    output logic [CNT_W-1:0] res_total_o,
    output logic             res_err_o
);

    // The strobe-rise cycle counts as the first cycle of a gap, so the
    // timeout fires when the gap reaches TIMEOUT_CYCLES cycles measured
    // from the strobe rise to res_valid_o.
    localparam logic [TIMEOUT_W-1:0] c_WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] c_WD_SAT  = TIMEOUT_W'(TIMEOUT_CYCLES);

    hit_accum_state_t r_state, w_state_nxt;

    logic                 r_stb_q;
    logic                 w_edge;
    logic                 w_cmp_s;
    logic [CNT_W-1:0]     r_n_req,  w_n_req_nxt;
    logic [CNT_W-1:0]     r_hits,   w_hits_nxt;
    logic [CNT_W-1:0]     r_total,  w_total_nxt;
    logic [CNT_W-1:0]     w_total_inc;
    logic                 r_err,    w_err_nxt;
    logic [TIMEOUT_W-1:0] r_wd,     w_wd_nxt;
    logic [TIMEOUT_W-1:0] w_wd_inc;
    logic                 w_timeout;

    sync_2ff #(
        .WIDTH (1)
    ) u_cmp_sync (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .d_i    (cmp_i),
        .q_o    (w_cmp_s)
    );

    assign w_edge      = stb_i & ~r_stb_q;
    assign w_wd_inc    = r_wd + TIMEOUT_W'(1);
    assign w_timeout   = (w_wd_inc >= c_WD_LAST);
    assign w_total_inc = r_total + CNT_W'(1);

    // Next-state and counter updates; abort beats strobe error beats
    // watchdog beats a strobe edge.
    always_comb begin
        w_state_nxt = r_state;
        w_n_req_nxt = r_n_req;
        w_hits_nxt  = r_hits;
        w_total_nxt = r_total;
        w_err_nxt   = r_err;
        w_wd_nxt    = r_wd;
        case (r_state)
            HA_IDLE: begin
                if (start_i) begin
                    w_n_req_nxt = n_samples_i;
                    w_hits_nxt  = '0;
                    w_total_nxt = '0;
                    w_err_nxt   = 1'b0;
                    w_wd_nxt    = '0;
                    w_state_nxt = (n_samples_i == '0) ? HA_DONE : HA_ARM;
                end
            end
            HA_ARM, HA_ACCUM: begin
                if (abort_i) begin
                    w_state_nxt = HA_IDLE;
                end else if (stb_err_i) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = HA_DONE;
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_wd_nxt    = c_WD_SAT;
                    w_state_nxt = HA_DONE;
                end else if (w_edge) begin
                    w_wd_nxt = '0;
                    if (r_state == HA_ARM) begin
                        // First strobe after lock is partial: discard it.
                        w_state_nxt = HA_ACCUM;
                    end else begin
                        w_total_nxt = w_total_inc;
                        w_hits_nxt  = r_hits + {{(CNT_W-1){1'b0}}, w_cmp_s};
                        if (w_total_inc == r_n_req) begin
                            w_state_nxt = HA_DONE;
                        end
                    end
                end else begin
                    w_wd_nxt = w_wd_inc;
                end
            end
            HA_DONE: begin
                if (res_ready_i) begin
                    w_state_nxt = HA_IDLE;
                end
            end
            default: begin
                w_state_nxt = HA_IDLE;
            end
        endcase
    end

    // State, counters and strobe delay register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= HA_IDLE;
            r_stb_q <= 1'b0;
            r_n_req <= '0;
            r_hits  <= '0;
            r_total <= '0;
            r_err   <= 1'b0;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stb_q <= stb_i;
            r_n_req <= w_n_req_nxt;
            r_hits  <= w_hits_nxt;
            r_total <= w_total_nxt;
            r_err   <= w_err_nxt;
            r_wd    <= w_wd_nxt;
        end
    end

    assign busy_o      = (r_state != HA_IDLE);
    assign res_valid_o = (r_state == HA_DONE);
    assign res_hits_o  = r_hits;
    assign res_total_o = r_total;
    assign res_err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_stb_hit_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stb_hit_accum
//  Description : Self-checking bench for stb_hit_accum with directed cases
//                and randomized measurements against a counting model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stb_hit_accum;

    localparam int c_CNT_W   = 16;
    localparam int c_TIMEOUT = 64;

    logic               clk_i       = 1'b0;
    logic               arst_i      = 1'b1;
    logic               stb_i       = 1'b0;
    logic               stb_err_i   = 1'b0;
    logic               cmp_i       = 1'b0;
    logic               start_i     = 1'b0;
    logic               abort_i     = 1'b0;
    logic [c_CNT_W-1:0] n_samples_i = '0;
    logic               res_ready_i = 1'b0;
    logic               busy_o;
    logic               res_valid_o;
    logic [c_CNT_W-1:0] res_hits_o;
    logic [c_CNT_W-1:0] res_total_o;
    logic               res_err_o;

    int n_vec = 0;
    int n_err = 0;
    bit v_at_rise;

    stb_hit_accum #(
        .CNT_W          (c_CNT_W),
        .TIMEOUT_W      (24),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) u_dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .stb_i       (stb_i),
        .stb_err_i   (stb_err_i),
        .cmp_i       (cmp_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .n_samples_i (n_samples_i),
        .busy_o      (busy_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_hits_o  (res_hits_o),
        .res_total_o (res_total_o),
        .res_err_o   (res_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_meas(input int n);
        @(negedge clk_i);
        start_i     = 1'b1;
        n_samples_i = c_CNT_W'(n);
        @(negedge clk_i);
        start_i     = 1'b0;
    endtask

    // One-cycle strobe after 'gap' cycles; cmp_i is set well ahead so the
    // synchronized copy has settled by the strobe rise.
    task automatic pulse_stb(input bit cmp, input int gap, input bit err);
        cmp_i = cmp;
        repeat (gap - 1) @(negedge clk_i);
        stb_i     = 1'b1;
        stb_err_i = err;
        v_at_rise = res_valid_o;
        @(negedge clk_i);
        stb_i     = 1'b0;
        stb_err_i = 1'b0;
    endtask

    task automatic accept(input string tag);
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        chk({tag, "_valid_after_ready"}, res_valid_o, 0);
        chk({tag, "_busy_after_ready"}, busy_o, 0);
    endtask

    // mode 0: full run of n; mode 1: stb_err on the strobe after k counted;
    // mode 2: abort after k counted strobes.
    task automatic run_meas(input int n, input int period, input int mode, input int k, input string tag);
        int exp_hits  = 0;
        int exp_total = 0;
        int n_edges;
        int hold;
        bit c;
        start_meas(n);
        pulse_stb(1'($urandom_range(0, 1)), period, 1'b0);
        n_edges = (mode == 0) ? n : k;
        for (int i = 0; i < n_edges; i++) begin
            c = 1'($urandom_range(0, 1));
            pulse_stb(c, period, 1'b0);
            exp_total++;
            exp_hits += int'(c);
        end
        if (mode == 1) begin
            pulse_stb(1'b1, period, 1'b1);
        end
        if (mode == 2) begin
            repeat (3) @(negedge clk_i);
            abort_i = 1'b1;
            @(negedge clk_i);
            abort_i = 1'b0;
            chk({tag, "_abort_busy"}, busy_o, 0);
            chk({tag, "_abort_valid"}, res_valid_o, 0);
            return;
        end
        chk({tag, "_valid_at_rise"}, v_at_rise, 0);
        chk({tag, "_valid"}, res_valid_o, 1);
        chk({tag, "_hits"}, res_hits_o, exp_hits);
        chk({tag, "_total"}, res_total_o, exp_total);
        chk({tag, "_err"}, res_err_o, (mode == 1) ? 1 : 0);
        hold = $urandom_range(0, 5);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            chk({tag, "_valid_held"}, res_valid_o, 1);
        end
        chk({tag, "_hits_held"}, res_hits_o, exp_hits);
        accept(tag);
    endtask

    initial begin
        int cnt;
        int changes;
        int mode;
        int n;
        int k;

        // Reset state
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", res_valid_o, 0);
        chk("rst_hits", res_hits_o, 0);
        chk("rst_total", res_total_o, 0);
        chk("rst_err", res_err_o, 0);
        #22 arst_i = 1'b0;

        // Basic accumulation: cmp=1 on counted strobes 2,4,6,8
        start_meas(8);
        pulse_stb(1'b1, 20, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            pulse_stb((i % 2) == 0, 20, 1'b0);
        end
        chk("basic_valid_at_rise", v_at_rise, 0);
        chk("basic_valid", res_valid_o, 1);
        chk("basic_hits", res_hits_o, 4);
        chk("basic_total", res_total_o, 8);
        chk("basic_err", res_err_o, 0);

        // Hold ready low for 50 cycles, with a start pulse in DONE
        changes = 0;
        for (int i = 0; i < 50; i++) begin
            start_i     = (i == 25);
            n_samples_i = 16'd3;
            @(negedge clk_i);
            if (res_valid_o !== 1'b1 || res_hits_o !== 16'd4 ||
                res_total_o !== 16'd8 || res_err_o !== 1'b0 || busy_o !== 1'b1)
                changes++;
        end
        start_i = 1'b0;
        chk("hold_stable", changes, 0);

        // Ready together with start in DONE: start must be ignored
        res_ready_i = 1'b1;
        start_i     = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        start_i     = 1'b0;
        chk("done_start_busy", busy_o, 0);
        chk("done_start_valid", res_valid_o, 0);

        // Zero samples
        start_meas(0);
        chk("zero_valid", res_valid_o, 1);
        chk("zero_hits", res_hits_o, 0);
        chk("zero_total", res_total_o, 0);
        chk("zero_err", res_err_o, 0);
        accept("zero");

        // Watchdog: strobes stop after 3 counted
        start_meas(10);
        pulse_stb(1'b0, 20, 1'b0);
        pulse_stb(1'b1, 20, 1'b0);
        pulse_stb(1'b0, 20, 1'b0);
        pulse_stb(1'b1, 20, 1'b0);
        cnt = 1;
        while (res_valid_o !== 1'b1 && cnt < 200) begin
            @(negedge clk_i);
            cnt++;
        end
        chk("wd_latency", cnt, c_TIMEOUT);
        chk("wd_err", res_err_o, 1);
        chk("wd_total", res_total_o, 3);
        chk("wd_hits", res_hits_o, 2);
        accept("wd");

        // stb_err_i coincident with 5th counted edge
        run_meas(10, 20, 1, 4, "stberr");

        // Abort during ACCUM
        run_meas(10, 15, 2, 2, "abort");
        repeat (5) @(negedge clk_i);
        chk("abort_no_valid_later", res_valid_o, 0);

        // Reset mid-run
        start_meas(10);
        pulse_stb(1'b1, 12, 1'b0);
        pulse_stb(1'b1, 12, 1'b0);
        pulse_stb(1'b1, 12, 1'b0);
        #2 arst_i = 1'b1;
        #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_valid", res_valid_o, 0);
        chk("midrst_hits", res_hits_o, 0);
        chk("midrst_total", res_total_o, 0);
        chk("midrst_err", res_err_o, 0);
        #1 arst_i = 1'b0;
        run_meas(2, 12, 0, 0, "post_rst");

        // Randomized measurements
        for (int it = 0; it < 25; it++) begin
            mode = $urandom_range(0, 2);
            n    = $urandom_range(1, 12);
            k    = $urandom_range(0, n - 1);
            run_meas(n, $urandom_range(5, 30), mode, k, $sformatf("rnd%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
